// File: rtl/write_buffer_fifo_pkg.sv
// write_buffer_fifo_pkg: shared widths, depth default and drain-state encodings for the write buffer
package write_buffer_fifo_pkg;
    localparam int MEM_ADDR_SIZE = 16;
    localparam int WORD_SIZE_BIT = 32;
    localparam int WB_DEPTH = 4;
    localparam int OCC_W = 5;
    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_ISSUE    = 2'd1,
        WB_WAIT_ACK = 2'd2
    } wb_state_t;
endpackage

// File: rtl/write_buffer_fifo_if.sv
// write_buffer_fifo_if: cache-side push/lookup and memory-side drain signals of the write buffer
interface write_buffer_fifo_if;
    import write_buffer_fifo_pkg::*;
    logic write_buffer, read_buffer, full, empty, buffer_hit;
    logic mem_write, mem_ack, overflow_sticky;
    logic [MEM_ADDR_SIZE-1:0] addr, mem_addr;
    logic [WORD_SIZE_BIT-1:0] wData, data_read_from_buffer, mem_wdata;
    logic [OCC_W-1:0] occupancy;
    modport slave(
        input  write_buffer, addr, wData, read_buffer, mem_ack,
        output full, empty, buffer_hit, data_read_from_buffer,
        output mem_write, mem_addr, mem_wdata, overflow_sticky, occupancy
    );
    modport master(
        output write_buffer, addr, wData, read_buffer, mem_ack,
        input  full, empty, buffer_hit, data_read_from_buffer,
        input  mem_write, mem_addr, mem_wdata, overflow_sticky, occupancy
    );
endinterface

// File: rtl/write_buffer_fifo_cam.sv
// wb_cam_match: parallel address compare over all entries, youngest match (furthest from head) wins
module wb_cam_match
    import write_buffer_fifo_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [MEM_ADDR_SIZE-1:0] tags [DEPTH],
    input  logic [MEM_ADDR_SIZE-1:0] key,
    input  logic [PW-1:0]            head,
    output logic                     hit,
    output logic [PW-1:0]            idx
);
    logic [PW-1:0] j;
    always_comb begin
        hit = 1'b0;
        idx = '0;
        j = '0;
        for (int k = 0; k < DEPTH; k++) begin
            j = head + PW'(k);
            if (valid[j] && tags[j] == key) begin
                hit = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/write_buffer_fifo.sv
// write_buffer_fifo: circular write buffer with merge-on-push, CAM lookup and a one-at-a-time memory drain FSM
module write_buffer_fifo
    import write_buffer_fifo_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input logic clock,
    input logic reset,
    write_buffer_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_state_t state, state_nx;
    logic [MEM_ADDR_SIZE-1:0] tags [DEPTH];
    logic [WORD_SIZE_BIT-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid, mg_valid;
    logic [PW-1:0] head, tail, lk_idx, mg_idx;
    logic [CW-1:0] count, count_nx;
    logic lk_hit, mg_hit, hit, push, append, merge, pop, full, empty, ovf;

    // the head being written to memory must not change under the write
    assign mg_valid = (state == WB_WAIT_ACK) ? valid & ~(DEPTH'(1) << head) : valid;

    wb_cam_match #(.DEPTH(DEPTH)) lookup_cam (
        .valid(valid), .tags(tags), .key(bus.addr), .head(head), .hit(lk_hit), .idx(lk_idx)
    );
    wb_cam_match #(.DEPTH(DEPTH)) merge_cam (
        .valid(mg_valid), .tags(tags), .key(bus.addr), .head(head), .hit(mg_hit), .idx(mg_idx)
    );

    assign push = bus.write_buffer && !full;
    assign merge = push && mg_hit;
    assign append = push && !mg_hit;
    assign pop = (state == WB_WAIT_ACK) && bus.mem_ack;
    assign count_nx = count + CW'(append) - CW'(pop);

    always_comb begin
        state_nx = state == WB_IDLE  ? (|count ? WB_ISSUE : WB_IDLE) :
                   state == WB_ISSUE ? WB_WAIT_ACK :
                   state == WB_WAIT_ACK ? (pop ? (|count_nx ? WB_ISSUE : WB_IDLE) : WB_WAIT_ACK) :
                   WB_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WB_IDLE;
            valid <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            ovf <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            full <= count_nx == CW'(DEPTH);
            empty <= count_nx == '0;
            ovf <= ovf | (bus.write_buffer && full);
            if (pop) begin
                valid[head] <= 1'b0;
                head <= head + PW'(1);
            end
            if (append) begin
                valid[tail] <= 1'b1;
                tail <= tail + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (append) begin
            tags[tail] <= bus.addr;
            data[tail] <= bus.wData;
        end
        if (merge) data[mg_idx] <= bus.wData;
    end

    assign hit = !reset && bus.read_buffer && lk_hit;
    assign bus.buffer_hit = hit;
    assign bus.data_read_from_buffer = hit ? data[lk_idx] : '0;
    assign bus.mem_write = state == WB_ISSUE || state == WB_WAIT_ACK;
    assign bus.mem_addr = bus.mem_write ? tags[head] : '0;
    assign bus.mem_wdata = bus.mem_write ? data[head] : '0;
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.overflow_sticky = ovf;
    assign bus.occupancy = OCC_W'(count);
endmodule

// File: doc/write_buffer_fifo.md
WRITE_BUFFER_FIFO -- requirements
Module: write_buffer_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of address/data entries (power of two, 2..16).
REQ-002 SHALL have port clock  in  1  single clock; all state changes on posedge; one clock, no other clock domain.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset; polarity and synchronicity are fixed.
REQ-004 SHALL have port write_buffer  in  1  push request from cache, sampled at posedge.
REQ-005 SHALL have port addr  in  `MEM_ADDR_SIZE  shared push/lookup word address.
REQ-006 SHALL have port wData  in  `WORD_SIZE_BIT  push data.
REQ-007 SHALL have port read_buffer  in  1  lookup strobe, where addr is compared against all entries.
REQ-008 SHALL have port full  out  1  registered; high when occupancy == DEPTH.
REQ-009 SHALL have port empty  out  1  registered; high when occupancy == 0.
REQ-010 SHALL have port buffer_hit  out  1  combinational lookup-match flag.
REQ-011 SHALL have port data_read_from_buffer  out  `WORD_SIZE_BIT  data of the matching entry; 0 when no hit.
REQ-012 SHALL have port mem_write  out  1  memory write request, held until acknowledged.
REQ-013 SHALL have port mem_addr / mem_wdata  out  `MEM_ADDR_SIZE / `WORD_SIZE_BIT  head entry driven to memory.
REQ-014 SHALL have port mem_ack  in  1  memory accepted the write in this cycle.

Function
REQ-015 SHALL store entries as a circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 SHALL ignore a push while full is high; no entry changes, count is unchanged, and the overflow_sticky debug flag is set.
REQ-017 SHALL merge a push whose addr matches a valid entry that is not in flight: data is overwritten in place, count is unchanged.
REQ-018 SHALL append a push that matches only the in-flight head entry (WAIT_ACK) as a new entry; it SHALL NOT modify the head.
REQ-019 SHALL drive buffer_hit = read_buffer AND (any valid entry addr == addr), combinationally, with zero latency.
REQ-020 SHALL return the youngest match on multiple matches (only possible per REQ-018).
REQ-021 SHALL use a drain FSM with states IDLE, ISSUE, WAIT_ACK:
 - IDLE->ISSUE when count>0.
 - ISSUE: assert mem_write with the head entry; go to WAIT_ACK next cycle.
 - WAIT_ACK: hold mem_write/mem_addr/mem_wdata stable; on mem_ack pop the head, then go to ISSUE if count-1>0, else IDLE.
REQ-022 SHALL give minimum push-to-mem_write latency of 2 cycles (push posedge N, state ISSUE after N+1, mem_write visible after N+1).
REQ-023 SHALL, on push and pop in the same cycle, apply both; count unchanged; a push at full SHALL still be rejected even if a pop occurs that cycle (full is registered).
REQ-024 SHALL hold mem_write=0 and mem_addr/mem_wdata=0 outside ISSUE/WAIT_ACK.
REQ-025 SHALL ignore mem_ack outside WAIT_ACK.
REQ-026 SHALL perform a lookup on the same cycle as a push against pre-push contents.

Reset
REQ-027 SHALL, on reset high at posedge, clear all valid bits, head, tail and count to 0, set state to IDLE, and take empty=1, full=0, mem_write=0, mem_addr=0, mem_wdata=0, overflow_sticky=0.
REQ-028 SHALL abandon an in-flight write on reset mid-operation; a mem_ack in the cycle after reset SHALL be ignored.
REQ-029 SHALL output buffer_hit=0 and data_read_from_buffer=0 during reset regardless of read_buffer.

Structure
REQ-030 SHALL take `MEM_ADDR_SIZE and `WORD_SIZE_BIT from sys_defs.vh, and SHALL add the drain-state encodings (WB_IDLE, WB_ISSUE, WB_WAIT_ACK) and the WB_DEPTH default there.
REQ-031 SHALL be implemented as one module; the parallel address comparator with youngest-first priority select is a natural sub-module, wb_cam_match.

Verification
REQ-032 SHALL cover single push: reset; push addr=0x040 data=0xDEADBEEF -> mem_write high 2 cycles later with 0x040/0xDEADBEEF; ack 3 cycles later -> empty=1.
REQ-033 SHALL cover fill: 4 pushes with no ack -> full=1; 5th push addr=0x100 is ignored, overflow_sticky=1; lookup 0x100 -> buffer_hit=0.
REQ-034 SHALL cover merge: push 0x080/0x1, 0x084/0x2, then 0x084/0x9 while the head is in flight -> count=2; lookup 0x084 returns 0x9; memory later sees 0x084/0x9 once.
REQ-035 SHALL cover in-flight append: head 0x080/0x1 in WAIT_ACK; push 0x080/0x5 -> count=2, lookup returns 0x5, mem_wdata stays 0x1 until ack.
REQ-036 SHALL cover simultaneous push and pop: count=2, mem_ack and push in the same cycle -> count stays 2, order preserved.
REQ-037 SHALL cover reset mid-WAIT_ACK: reset asserted -> mem_write=0 and empty=1 next cycle; a subsequent stray mem_ack has no effect.
